// File: rtl/uart_frame_ctrl.sv
// rtl/uart_frame_ctrl.sv - framed UART byte sequencer into the pulse-parameter RAM
//
// Purpose: accepts bytes from the UART receiver. A frame is an SOF byte followed by
// N_BYTES of payload, plus a sum8 checksum byte when UART_FRAME_CSUM_EN is defined.
// Payload is written to RAM at descending addresses N_BYTES..1. cfg_valid_o is raised
// only after a complete, verified frame. An inter-byte timeout inside a frame aborts it.
//
// Build option: `define UART_FRAME_CSUM_EN adds the checksum byte and the CHK state.
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous reset, active-high
//   rx_data_i     receiver byte, stable while rx_wr_n_i is low
//   rx_wr_n_i     receiver byte-ready, active-low, asynchronous to clk_i
//   mem_we_o      RAM write enable, one pulse per payload byte
//   mem_addr_o    RAM write address
//   mem_wdata_o   RAM write data
//   busy_o        frame in progress
//   cfg_valid_o   RAM holds a complete verified frame
//   frame_ok_o    one-cycle pulse on commit
//   frame_err_o   one-cycle pulse on abort
//   err_cnt_o     saturating count of aborted frames
module uart_frame_ctrl #(
    parameter int         N_BYTES = 112,
    parameter logic [7:0] SOF     = 8'hA5,
    parameter int         TIMEOUT = 50000,
    parameter int         TO_W    = 16,
    localparam int        AW      = $clog2(N_BYTES + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_wr_n_i,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_wdata_o,
    output logic          busy_o,
    output logic          cfg_valid_o,
    output logic          frame_ok_o,
    output logic          frame_err_o,
    output logic [7:0]    err_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PAY    = 3'd1,
`ifdef UART_FRAME_CSUM_EN
        S_CHK    = 3'd2,
`endif
        S_COMMIT = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      rx_sync_q;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            cfg_q, cfg_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            pend_q, pend_d;
    logic [7:0]      pend_data_q, pend_data_d;
`ifdef UART_FRAME_CSUM_EN
    logic [7:0]      sum_q, sum_d;
`endif

    logic            byte_stb;
    logic            in_valid;
    logic [7:0]      in_data;
    logic            last_wr;
    logic            to_hit;

    // [0] and [1] form the synchronizer; [2] holds the previous synchronized level.
    // Reset to idle-high so leaving reset never fakes a falling edge.
    assign byte_stb = rx_sync_q[2] & ~rx_sync_q[1];

    // A byte caught during COMMIT/ERROR is replayed from the pending slot in IDLE.
    assign in_valid = pend_q | byte_stb;
    assign in_data  = pend_q ? pend_data_q : rx_data_i;

    // The write of the last payload byte is visible this cycle; leave PAY only now so
    // mem_we_o never shows up outside PAY.
    assign last_wr  = we_q && (addr_q == AW'(1));
    assign to_hit   = (to_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = 1'b0;
        wdata_d     = wdata_q;
        cfg_d       = cfg_q;
        err_cnt_d   = err_cnt_q;
        to_d        = '0;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
`ifdef UART_FRAME_CSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                if (in_valid && in_data == SOF) begin
                    state_d = S_PAY;
                    cfg_d   = 1'b0;
                    addr_d  = AW'(N_BYTES);
`ifdef UART_FRAME_CSUM_EN
                    sum_d   = 8'd0;
`endif
                end
            end
            S_PAY: begin
                if (byte_stb) begin
                    we_d    = 1'b1;
                    wdata_d = rx_data_i;
`ifdef UART_FRAME_CSUM_EN
                    sum_d   = sum_q + rx_data_i;
`endif
                end else if (last_wr) begin
`ifdef UART_FRAME_CSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_COMMIT;
`endif
                end else if (to_hit) begin
                    state_d = S_ERROR;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
                if (we_q && !last_wr) begin
                    addr_d = addr_q - AW'(1);
                end
            end
`ifdef UART_FRAME_CSUM_EN
            S_CHK: begin
                if (byte_stb) begin
                    state_d = (rx_data_i == sum_q) ? S_COMMIT : S_ERROR;
                end else if (to_hit) begin
                    state_d = S_ERROR;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
`endif
            S_COMMIT: begin
                state_d = S_IDLE;
                cfg_d   = 1'b1;
                addr_d  = AW'(N_BYTES);
                if (byte_stb) begin
                    pend_d      = 1'b1;
                    pend_data_d = rx_data_i;
                end
            end
            S_ERROR: begin
                state_d = S_IDLE;
                addr_d  = AW'(N_BYTES);
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                if (byte_stb) begin
                    pend_d      = 1'b1;
                    pend_data_d = rx_data_i;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_sync_q   <= 3'b111;
            state_q     <= S_IDLE;
            addr_q      <= AW'(N_BYTES);
            we_q        <= 1'b0;
            wdata_q     <= 8'd0;
            cfg_q       <= 1'b0;
            err_cnt_q   <= 8'd0;
            to_q        <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= 8'd0;
`ifdef UART_FRAME_CSUM_EN
            sum_q       <= 8'd0;
`endif
        end else begin
            rx_sync_q   <= {rx_sync_q[1:0], rx_wr_n_i};
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            cfg_q       <= cfg_d;
            err_cnt_q   <= err_cnt_d;
            to_q        <= to_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
`ifdef UART_FRAME_CSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
`ifdef UART_FRAME_CSUM_EN
    assign busy_o      = (state_q == S_PAY) || (state_q == S_CHK);
`else
    assign busy_o      = (state_q == S_PAY);
`endif
    assign cfg_valid_o = cfg_q;
    assign frame_ok_o  = (state_q == S_COMMIT);
    assign frame_err_o = (state_q == S_ERROR);
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb/tb_uart_frame_ctrl.sv - randomized self-checking bench for uart_frame_ctrl
module tb_uart_frame_ctrl;
    localparam int         N   = 112;
    localparam int         TO  = 100;
    localparam logic [7:0] SOF = 8'hA5;
`ifdef UART_FRAME_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, rx_wr_n, mem_we, busy, cfg_valid, frame_ok, frame_err;
    logic [7:0] rx_data, mem_wdata, err_cnt;
    logic [6:0] mem_addr;

    always #5 clk = ~clk;

    uart_frame_ctrl #(.N_BYTES(N), .SOF(SOF), .TIMEOUT(TO), .TO_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_wr_n_i(rx_wr_n),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .busy_o(busy), .cfg_valid_o(cfg_valid), .frame_ok_o(frame_ok),
        .frame_err_o(frame_err), .err_cnt_o(err_cnt)
    );

    int          n_cmp = 0, n_bad = 0;
    int          ok_cnt = 0, err_pulses = 0, exp_err = 0;
    logic [14:0] got_q[$];
    logic [7:0]  pay [N];

    // Monitor: records RAM writes, counts pulses, and checks writes only occur mid-frame.
    always @(negedge clk) begin
        if (mem_we) begin
            got_q.push_back({mem_addr, mem_wdata});
            n_cmp++;
            if (!busy) begin
                n_bad++;
                $display("FAIL we_outside_frame: busy=%0b required 1", busy);
            end
        end
        if (frame_ok)  ok_cnt++;
        if (frame_err) err_pulses++;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Reference checksum: modulo-256 sum of the payload.
    function automatic logic [7:0] model_sum();
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(pay[i]);
        return 8'(s % 256);
    endfunction

    task automatic send_byte(input logic [7:0] b, input int lo, input int hi);
        rx_data = b;
        rx_wr_n = 1'b0;
        repeat (lo) @(negedge clk);
        rx_wr_n = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    task automatic send_rand(input logic [7:0] b);
        send_byte(b, int'($urandom_range(2, 4)), int'($urandom_range(2, 8)));
    endtask

    task automatic send_frame(input logic [7:0] csum_b);
        send_rand(SOF);
        for (int i = 0; i < N; i++) send_rand(pay[i]);
        if (CSUM) send_rand(csum_b);
    endtask

    task automatic wait_ok(input int base, input int budget);
        for (int c = 0; c < budget && ok_cnt == base; c++) @(negedge clk);
    endtask

    task automatic wait_err(input int base, input int budget);
        for (int c = 0; c < budget && err_pulses == base; c++) @(negedge clk);
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) pay[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_wr_n = 1'b1; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_we !== 1'b0)      begin n_bad++; $display("FAIL reset_we: got %0b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 7'(N))   begin n_bad++; $display("FAIL reset_addr: got %0d want %0d", mem_addr, N); end
        n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (cfg_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_cfg: got %0b want 0", cfg_valid); end
        n_cmp++; if (frame_ok !== 1'b0)    begin n_bad++; $display("FAIL reset_ok: got %0b want 0", frame_ok); end
        n_cmp++; if (frame_err !== 1'b0)   begin n_bad++; $display("FAIL reset_err: got %0b want 0", frame_err); end
        n_cmp++; if (err_cnt !== 8'd0)     begin n_bad++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_good_frame();
        int ok0 = ok_cnt, err0 = err_pulses;
        logic [14:0] g;
        for (int i = 0; i < N; i++) pay[i] = 8'(i);
        got_q.delete();
        send_frame(model_sum());
        wait_ok(ok0, 30);
        n_cmp++; if (got_q.size() != N) begin n_bad++; $display("FAIL good_nwrites: got %0d want %0d", got_q.size(), N); end
        for (int i = 0; i < N; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 15'hx;
            n_cmp++;
            if (g !== {7'(N - i), pay[i]}) begin
                n_bad++;
                $display("FAIL good_write[%0d]: got addr %0d data %0h want addr %0d data %0h", i, g[14:8], g[7:0], N - i, pay[i]);
            end
        end
        n_cmp++; if (ok_cnt != ok0 + 1)    begin n_bad++; $display("FAIL good_ok: got %0d pulses want 1", ok_cnt - ok0); end
        n_cmp++; if (err_pulses != err0)   begin n_bad++; $display("FAIL good_noerr: got %0d pulses want 0", err_pulses - err0); end
        @(negedge clk);
        n_cmp++; if (cfg_valid !== 1'b1)   begin n_bad++; $display("FAIL good_cfg: got %0b want 1", cfg_valid); end
        n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL good_busy: got %0b want 0", busy); end
        n_cmp++; if (mem_addr !== 7'(N))   begin n_bad++; $display("FAIL good_addr: got %0d want %0d", mem_addr, N); end
    endtask

    task automatic test_idle_noise();
        logic [7:0] b;
        got_q.delete();
        send_rand(8'h00);
        send_rand(8'h3C);
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom_range(0, 255));
            if (b == SOF) b = 8'h5A;
            send_rand(b);
        end
        repeat (5) @(negedge clk);
        n_cmp++; if (got_q.size() != 0)     begin n_bad++; $display("FAIL noise_writes: got %0d want 0", got_q.size()); end
        n_cmp++; if (busy !== 1'b0)         begin n_bad++; $display("FAIL noise_busy: got %0b want 0", busy); end
        n_cmp++; if (err_cnt !== 8'(exp_err)) begin n_bad++; $display("FAIL noise_errcnt: got %0d want %0d", err_cnt, exp_err); end
        n_cmp++; if (cfg_valid !== 1'b1)    begin n_bad++; $display("FAIL noise_cfg: got %0b want 1", cfg_valid); end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 3; f++) begin
            int ok0 = ok_cnt, bad_i = -1;
            logic [14:0] g;
            fill_random();
            pay[$urandom_range(0, N - 1)] = SOF;
            got_q.delete();
            send_frame(model_sum());
            wait_ok(ok0, 30);
            for (int i = 0; i < N; i++) begin
                g = (i < got_q.size()) ? got_q[i] : 15'hx;
                if (g !== {7'(N - i), pay[i]} && bad_i < 0) bad_i = i;
            end
            n_cmp++; if (bad_i >= 0 || got_q.size() != N) begin n_bad++; $display("FAIL rand_writes[%0d]: first bad index %0d, count %0d want %0d", f, bad_i, got_q.size(), N); end
            n_cmp++; if (ok_cnt != ok0 + 1) begin n_bad++; $display("FAIL rand_ok[%0d]: got %0d pulses want 1", f, ok_cnt - ok0); end
        end
    endtask

    task automatic test_timeout();
        int err0 = err_pulses;
        fill_random();
        got_q.delete();
        send_rand(SOF);
        for (int i = 0; i < 49; i++) send_rand(pay[i]);
        send_byte(pay[49], 2, 2);
        repeat (TO - 10) @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || err_pulses != err0) begin n_bad++; $display("FAIL to_early: busy %0b err pulses %0d want busy 1 pulses 0", busy, err_pulses - err0); end
        wait_err(err0, 40);
        exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        @(negedge clk);
        n_cmp++; if (err_pulses != err0 + 1)  begin n_bad++; $display("FAIL to_pulse: got %0d pulses want 1", err_pulses - err0); end
        n_cmp++; if (err_cnt !== 8'(exp_err)) begin n_bad++; $display("FAIL to_errcnt: got %0d want %0d", err_cnt, exp_err); end
        n_cmp++; if (cfg_valid !== 1'b0)      begin n_bad++; $display("FAIL to_cfg: got %0b want 0", cfg_valid); end
        n_cmp++; if (mem_addr !== 7'(N))      begin n_bad++; $display("FAIL to_addr: got %0d want %0d", mem_addr, N); end
        n_cmp++; if (busy !== 1'b0)           begin n_bad++; $display("FAIL to_busy: got %0b want 0", busy); end
        n_cmp++; if (got_q.size() != 50)      begin n_bad++; $display("FAIL to_writes: got %0d want 50", got_q.size()); end
    endtask

    task automatic test_bad_csum();
`ifdef UART_FRAME_CSUM_EN
        int ok0 = ok_cnt, err0 = err_pulses;
        for (int i = 0; i < N; i++) pay[i] = 8'(i);
        send_frame(model_sum() + 8'd1);
        wait_err(err0, 30);
        exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        @(negedge clk);
        n_cmp++; if (err_pulses != err0 + 1)  begin n_bad++; $display("FAIL csum_err: got %0d pulses want 1", err_pulses - err0); end
        n_cmp++; if (ok_cnt != ok0)           begin n_bad++; $display("FAIL csum_nook: got %0d pulses want 0", ok_cnt - ok0); end
        n_cmp++; if (cfg_valid !== 1'b0)      begin n_bad++; $display("FAIL csum_cfg: got %0b want 0", cfg_valid); end
        n_cmp++; if (err_cnt !== 8'(exp_err)) begin n_bad++; $display("FAIL csum_errcnt: got %0d want %0d", err_cnt, exp_err); end
        fill_random();
        send_frame(model_sum());
        wait_ok(ok0, 30);
        @(negedge clk);
        n_cmp++; if (ok_cnt != ok0 + 1)       begin n_bad++; $display("FAIL csum_good_ok: got %0d pulses want 1", ok_cnt - ok0); end
        n_cmp++; if (cfg_valid !== 1'b1)      begin n_bad++; $display("FAIL csum_good_cfg: got %0b want 1", cfg_valid); end
`endif
    endtask

    // Tail byte of one frame immediately followed by the next SOF; the tail is made equal
    // to SOF so rx_data stays stable across the tightly spaced strobes.
    task automatic test_back_to_back();
        for (int gap = 0; gap < 3; gap++) begin
            int ok0 = ok_cnt, bad_i = -1;
            logic [14:0] g;
            fill_random();
            pay[N - 1] = 8'h00;
            if (!CSUM) pay[N - 1] = SOF;
            else       pay[N - 1] = SOF - model_sum();
            got_q.delete();
            send_rand(SOF);
            for (int i = 0; i < N - 1; i++) send_rand(pay[i]);
            if (CSUM) send_rand(pay[N - 1]);
            send_byte(SOF, 1, 1 + gap);
            send_byte(SOF, 1, 3);
            wait_ok(ok0, 20);
            n_cmp++; if (ok_cnt != ok0 + 1) begin n_bad++; $display("FAIL b2b_ok1[%0d]: got %0d pulses want 1", gap, ok_cnt - ok0); end
            for (int c = 0; c < 10 && busy !== 1'b1; c++) @(negedge clk);
            n_cmp++; if (busy !== 1'b1)     begin n_bad++; $display("FAIL b2b_busy[%0d]: got %0b want 1", gap, busy); end
            n_cmp++; if (cfg_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_cfgdrop[%0d]: got %0b want 0", gap, cfg_valid); end
            for (int i = 0; i < N; i++) begin
                g = (i < got_q.size()) ? got_q[i] : 15'hx;
                if (g !== {7'(N - i), pay[i]} && bad_i < 0) bad_i = i;
            end
            n_cmp++; if (bad_i >= 0 || got_q.size() != N) begin n_bad++; $display("FAIL b2b_writes1[%0d]: first bad %0d count %0d", gap, bad_i, got_q.size()); end
            got_q.delete();
            fill_random();
            for (int i = 0; i < N; i++) send_rand(pay[i]);
            if (CSUM) send_rand(model_sum());
            wait_ok(ok0 + 1, 30);
            bad_i = -1;
            for (int i = 0; i < N; i++) begin
                g = (i < got_q.size()) ? got_q[i] : 15'hx;
                if (g !== {7'(N - i), pay[i]} && bad_i < 0) bad_i = i;
            end
            n_cmp++; if (bad_i >= 0 || got_q.size() != N) begin n_bad++; $display("FAIL b2b_writes2[%0d]: first bad %0d count %0d", gap, bad_i, got_q.size()); end
            n_cmp++; if (ok_cnt != ok0 + 2) begin n_bad++; $display("FAIL b2b_ok2[%0d]: got %0d pulses want 2", gap, ok_cnt - ok0); end
        end
    endtask

    task automatic test_reset_midframe();
        int ok0;
        fill_random();
        got_q.delete();
        send_rand(SOF);
        for (int i = 0; i < 60; i++) send_rand(pay[i]);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_err = 0;
        n_cmp++; if (got_q.size() != 60)    begin n_bad++; $display("FAIL rstmid_before: got %0d writes want 60", got_q.size()); end
        repeat (20) @(negedge clk);
        n_cmp++; if (got_q.size() != 60)    begin n_bad++; $display("FAIL rstmid_nowe: got %0d writes want 60", got_q.size()); end
        n_cmp++; if (busy !== 1'b0)         begin n_bad++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
        n_cmp++; if (cfg_valid !== 1'b0)    begin n_bad++; $display("FAIL rstmid_cfg: got %0b want 0", cfg_valid); end
        n_cmp++; if (err_cnt !== 8'd0)      begin n_bad++; $display("FAIL rstmid_errcnt: got %0d want 0", err_cnt); end
        n_cmp++; if (mem_addr !== 7'(N))    begin n_bad++; $display("FAIL rstmid_addr: got %0d want %0d", mem_addr, N); end
        ok0 = ok_cnt;
        fill_random();
        send_frame(model_sum());
        wait_ok(ok0, 30);
        @(negedge clk);
        n_cmp++; if (ok_cnt != ok0 + 1)     begin n_bad++; $display("FAIL rstmid_ok: got %0d pulses want 1", ok_cnt - ok0); end
        n_cmp++; if (cfg_valid !== 1'b1)    begin n_bad++; $display("FAIL rstmid_cfg2: got %0b want 1", cfg_valid); end
    endtask

    task automatic test_err_saturate();
        int err0 = err_pulses;
        for (int k = 0; k < 256; k++) begin
            int e0 = err_pulses;
            send_rand(SOF);
            wait_err(e0, TO + 30);
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            @(negedge clk);
            if (k == 254) begin
                n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_reach: got %0d want 255", err_cnt); end
            end
        end
        n_cmp++; if (err_pulses != err0 + 256) begin n_bad++; $display("FAIL sat_pulses: got %0d want 256", err_pulses - err0); end
        n_cmp++; if (err_cnt !== 8'(exp_err))  begin n_bad++; $display("FAIL sat_hold: got %0d want %0d", err_cnt, exp_err); end
    endtask

    initial begin
        rst = 1'b1; rx_wr_n = 1'b1; rx_data = 8'h00;
        test_reset();
        test_good_frame();
        test_idle_noise();
        test_random_frames();
        test_timeout();
        test_bad_csum();
        test_back_to_back();
        test_reset_midframe();
        test_err_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
